blackjack_round_ctrl: RTL and testbench

Sequential round controller that consumes the card stream from the card-dealing stage and plays one blackjack round: deals two cards each to player and dealer, runs the player's hit/stand turn, auto-plays the dealer, and declares the result. It sits directly downstream of the dealer/card-generation block. It replaces that block's fixed parallel card outputs with a request/valid handshake, one card per transfer. Its 5-bit totals feed the display and scoring logic.

---
 rtl/blackjack_round_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_blackjack_round_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round controller: deals, runs the player turn and dealer
// auto-play over a one-card request/valid handshake, then scores the round.
module blackjack_round_ctrl #(
    parameter logic [4:0] DEALER_STAND = 5'd17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    input  logic [5:0] card_in,
    input  logic       card_valid,
    output logic       card_req,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic [3:0] card_count,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic       error
);

    typedef enum logic [3:0] {
        IDLE,
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        PLAYER,
        P_DRAW,
        DEALER,
        D_DRAW,
        RESOLVE,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [4:0] p_hard, d_hard;
    logic       p_ace, d_ace;
    logic [3:0] count_q;
    logic [1:0] result_q;
    logic       error_q;

    logic [3:0] rank;
    logic       rank_ok;
    logic       is_ace;
    logic [4:0] card_val;
    logic       xfer;
    logic       to_player;
    logic       can_start;
    logic [4:0] p_new_hard, d_new_hard;
    logic       p_new_ace, d_new_ace;
    logic [4:0] p_best, d_best, pn_best;
    logic [1:0] res_calc;
    logic       unused_suit;

    function automatic logic [4:0] best_total(input logic [4:0] hard,
                                              input logic       ace);
        if (ace && hard <= 5'd11)
            return hard + 5'd10;
        return hard;
    endfunction

    assign rank        = card_in[5:2];
    assign unused_suit = ^card_in[1:0];
    assign rank_ok     = (rank != 4'd0) && (rank <= 4'd13);
    assign is_ace      = (rank == 4'd1);
    assign card_val    = (rank > 4'd10) ? 5'd10 : {1'b0, rank};

    assign card_req = (state == DEAL_P1) || (state == DEAL_D1) ||
                      (state == DEAL_P2) || (state == DEAL_D2) ||
                      (state == P_DRAW)  || (state == D_DRAW);
    assign xfer      = card_req && card_valid;
    assign to_player = (state == DEAL_P1) || (state == DEAL_P2) ||
                       (state == P_DRAW);
    assign can_start = start && ((state == IDLE) || (state == DONE));

    assign p_new_hard = p_hard + card_val;
    assign d_new_hard = d_hard + card_val;
    assign p_new_ace  = p_ace | is_ace;
    assign d_new_ace  = d_ace | is_ace;

    assign p_best  = best_total(p_hard, p_ace);
    assign d_best  = best_total(d_hard, d_ace);
    assign pn_best = best_total(p_new_hard, p_new_ace);

    always_comb begin
        res_calc = 2'b11;
        priority case (1'b1)
            (p_hard > 5'd21):  res_calc = 2'b10;
            (d_hard > 5'd21):  res_calc = 2'b01;
            (p_best > d_best): res_calc = 2'b01;
            (p_best < d_best): res_calc = 2'b10;
            default:           res_calc = 2'b11;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (start) state_nx = DEAL_P1;
            DEAL_P1:    if (xfer) state_nx = DEAL_D1;
            DEAL_D1:    if (xfer) state_nx = DEAL_P2;
            DEAL_P2:    if (xfer) state_nx = DEAL_D2;
            DEAL_D2: begin
                if (xfer)
                    state_nx = (p_best == 5'd21) ? DEALER : PLAYER;
            end
            PLAYER: begin
                if (stand)
                    state_nx = DEALER;
                else if (hit)
                    state_nx = P_DRAW;
            end
            P_DRAW: begin
                if (xfer) begin
                    if (p_new_hard > 5'd21)
                        state_nx = RESOLVE;
                    else if (pn_best == 5'd21)
                        state_nx = DEALER;
                    else
                        state_nx = PLAYER;
                end
            end
            DEALER:  state_nx = (d_best < DEALER_STAND) ? D_DRAW : RESOLVE;
            D_DRAW:  if (xfer) state_nx = DEALER;
            RESOLVE: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        // A bad rank aborts the round from any dealing state
        if (xfer && !rank_ok)
            state_nx = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_hard   <= '0;
            d_hard   <= '0;
            p_ace    <= 1'b0;
            d_ace    <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else if (can_start) begin
            p_hard   <= '0;
            d_hard   <= '0;
            p_ace    <= 1'b0;
            d_ace    <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else if (xfer) begin
            if (!rank_ok) begin
                error_q  <= 1'b1;
                result_q <= 2'b00;
            end else begin
                if (count_q != 4'd15)
                    count_q <= count_q + 4'd1;
                if (to_player) begin
                    p_hard <= p_new_hard;
                    p_ace  <= p_new_ace;
                end else begin
                    d_hard <= d_new_hard;
                    d_ace  <= d_new_ace;
                end
            end
        end else if (state == RESOLVE) begin
            result_q <= res_calc;
        end
    end

    assign player_total = p_best;
    assign dealer_total = d_best;
    assign card_count   = count_q;
    assign result       = result_q;
    assign error        = error_q;
    assign busy         = (state != IDLE) && (state != DONE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Bench for blackjack_round_ctrl: hands kept as card queues, totals and
// results recomputed from the game rules and compared every cycle.
module tb_blackjack_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, hit, stand;
    logic [5:0] card_in;
    logic       card_valid;
    logic       card_req;
    logic [4:0] player_total, dealer_total;
    logic [3:0] card_count;
    logic       busy, done, error;
    logic [1:0] result;

    blackjack_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hit          (hit),
        .stand        (stand),
        .card_in      (card_in),
        .card_valid   (card_valid),
        .card_req     (card_req),
        .player_total (player_total),
        .dealer_total (dealer_total),
        .card_count   (card_count),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .error        (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    int pq[$];
    int dq[$];
    int dsrc[$];
    int m_count;
    int m_req, m_busy, m_done, m_res, m_err;

    function automatic int cval(input int code);
        int r;
        r = (code >> 2) & 15;
        if (r == 1) return 1;
        if (r > 10) return 10;
        return r;
    endfunction

    function automatic int hard_of(input int q[$]);
        int s;
        s = 0;
        foreach (q[i]) s += cval(q[i]);
        return s;
    endfunction

    function automatic int best_of(input int q[$]);
        int h;
        bit a;
        h = hard_of(q);
        a = 1'b0;
        foreach (q[i]) if (cval(q[i]) == 1) a = 1'b1;
        if (a && h + 10 <= 21) return h + 10;
        return h;
    endfunction

    function automatic int score();
        int pt, dt;
        pt = best_of(pq);
        dt = best_of(dq);
        if (hard_of(pq) > 21) return 2;
        if (hard_of(dq) > 21) return 1;
        if (pt > dt) return 1;
        if (pt < dt) return 2;
        return 3;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("card_req", int'(card_req), m_req);
            chk("busy", int'(busy), m_busy);
            chk("done", int'(done), m_done);
            chk("result", int'(result), m_res);
            chk("error", int'(error), m_err);
            chk("card_count", int'(card_count), m_count);
            chk("player_total", int'(player_total), best_of(pq));
            chk("dealer_total", int'(dealer_total), best_of(dq));
        end
    end

    task automatic model_clear();
        pq.delete();
        dq.delete();
        m_count = 0;
        m_res   = 0;
        m_err   = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
        m_req  = 1;
        m_busy = 1;
        m_done = 0;
    endtask

    task automatic give(input bit to_p, input int code);
        card_in    = code[5:0];
        card_valid = 1'b1;
        step();
        card_valid = 1'b0;
        if (to_p) pq.push_back(code);
        else      dq.push_back(code);
        if (m_count < 15) m_count++;
    endtask

    task automatic give_bad(input int code);
        card_in    = code[5:0];
        card_valid = 1'b1;
        step();
        card_valid = 1'b0;
        m_err  = 1;
        m_res  = 0;
        m_req  = 0;
        m_busy = 0;
        m_done = 1;
    endtask

    task automatic finish_round();
        step();
        m_busy = 0;
        m_done = 1;
        m_res  = score();
    endtask

    task automatic dealer_phase();
        for (int i = 0; i < 8; i++) begin
            step();
            if (best_of(dq) < 17) begin
                m_req = 1;
                give(1'b0, dsrc.pop_front());
                m_req = 0;
            end else begin
                m_req = 0;
                finish_round();
                return;
            end
        end
    endtask

    task automatic deal4(input int a, input int b, input int c, input int d);
        do_start();
        give(1'b1, a);
        give(1'b0, b);
        give(1'b1, c);
        give(1'b0, d);
        m_req = 0;
        if (best_of(pq) == 21) dealer_phase();
    endtask

    task automatic p_hit(input int code);
        hit = 1'b1;
        step();
        hit = 1'b0;
        m_req = 1;
        give(1'b1, code);
        m_req = 0;
        if (hard_of(pq) > 21) finish_round();
        else if (best_of(pq) == 21) dealer_phase();
    endtask

    task automatic p_stand(input bit also_hit);
        stand = 1'b1;
        hit   = also_hit;
        step();
        stand = 1'b0;
        hit   = 1'b0;
        m_req = 0;
        dealer_phase();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        hit = 1'b0;
        stand = 1'b0;
        card_in = '0;
        card_valid = 1'b0;
        model_clear();
        m_req = 0; m_busy = 0; m_done = 0;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_total", int'(player_total), 0);
        chk_on = 1'b1;
        rst = 1'b0;
        step();

        // natural: A,10,K,7
        deal4('h04, 'h28, 'h34, 'h1C);
        chk("nat_player", int'(player_total), 21);
        chk("nat_dealer", int'(dealer_total), 17);
        chk("nat_result", int'(result), 1);
        chk("nat_count", int'(card_count), 4);
        step();
        step();

        // player bust on a hit
        deal4('h28, 'h28, 'h18, 'h1C);
        p_hit('h28);
        chk("bust_player", int'(player_total), 26);
        chk("bust_dealer", int'(dealer_total), 17);
        chk("bust_result", int'(result), 2);
        repeat (3) step();

        // soft ace, stray card_valid, dealer bust
        deal4('h04, 'h28, 'h14, 'h18);
        chk("soft_player", int'(player_total), 16);
        chk("soft_dealer", int'(dealer_total), 16);
        card_in = 6'h28;
        card_valid = 1'b1;
        step();
        card_valid = 1'b0;
        p_hit('h28);
        chk("hard_player", int'(player_total), 16);
        dsrc = '{'h28};
        p_stand(1'b0);
        chk("dbust_dealer", int'(dealer_total), 26);
        chk("dbust_result", int'(result), 1);
        step();

        // push, start ignored mid-round, hit+stand acts as stand
        deal4('h28, 'h28, 'h1C, 'h1C);
        start = 1'b1;
        step();
        start = 1'b0;
        p_stand(1'b1);
        chk("push_player", int'(player_total), 17);
        chk("push_dealer", int'(dealer_total), 17);
        chk("push_result", int'(result), 3);
        step();

        // stall in DEAL_D1, then async reset in PLAYER
        do_start();
        give(1'b1, 'h28);
        repeat (5) step();
        chk("stall_req", int'(card_req), 1);
        give(1'b0, 'h28);
        give(1'b1, 'h18);
        give(1'b0, 'h1C);
        m_req = 0;
        step();
        chk("pre_rst_player", int'(player_total), 16);
        rst = 1'b1;
        model_clear();
        m_busy = 0;
        m_done = 0;
        #2;
        chk("arst_player", int'(player_total), 0);
        chk("arst_dealer", int'(dealer_total), 0);
        chk("arst_count", int'(card_count), 0);
        chk("arst_busy", int'(busy), 0);
        step();
        rst = 1'b0;
        step();

        // invalid rank during DEAL_P2
        do_start();
        give(1'b1, 'h28);
        give(1'b0, 'h28);
        give_bad('h00);
        chk("bad_error", int'(error), 1);
        chk("bad_done", int'(done), 1);
        chk("bad_result", int'(result), 0);
        step();
        do_start();
        chk("restart_error", int'(error), 0);
        chk("restart_req", int'(card_req), 1);
        step();

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
